// File: rtl/polyphase_fir_y.sv
// Vertical polyphase decimator: weights dec_y rows per group
// and accumulates per column in a one-line accumulator RAM.
module polyphase_fir_y #(
  parameter int MAX_LINE_W = 640,
  parameter int MAX_Y_DEC  = 7,
  parameter int COEF_W     = 4,
  parameter int ACC_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic [9:0]                  line_w,
  input  logic [10:0]                 frame_lines,
  input  logic [2:0]                  dec_y,
  input  logic [MAX_Y_DEC*COEF_W-1:0] coef,
  input  logic [2:0]                  normalize,
  input  logic                        in_valid,
  input  logic [7:0]                  in_pix,
  output logic                        out_valid,
  output logic [7:0]                  out_pix,
  output logic                        out_eol,
  output logic                        frame_done,
  output logic                        cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [9:0]        line_w_r;
  logic [10:0]       lines_r;
  logic [2:0]        dec_r;
  logic [2:0]        norm_r;
  logic [COEF_W-1:0] coef_r [MAX_Y_DEC];

  logic [9:0]  col;
  logic [2:0]  phase;
  logic [10:0] row;

  logic [ACC_W-1:0] acc [MAX_LINE_W];

  logic             bad_cfg;
  logic             accept;
  logic             last_col;
  logic             last_phase;
  logic             last_row;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shifted;
  logic [7:0]       sat;

  assign bad_cfg = (dec_y == 3'd0)
                || ({1'b0, dec_y} > 4'(MAX_Y_DEC))
                || (line_w == 10'd0)
                || ({1'b0, line_w} > 11'(MAX_LINE_W))
                || (frame_lines == 11'd0);

  assign accept     = in_valid && !frame_start
                   && (state_q == RUN);
  assign last_col   = (col == line_w_r - 10'd1);
  assign last_phase = (phase == dec_r - 3'd1);
  assign last_row   = (row == lines_r - 11'd1);

  // Phase 0 overwrites the stale column value, so no clear pass.
  assign term    = ACC_W'(in_pix) * ACC_W'(coef_r[phase]);
  assign base    = (phase == 3'd0) ? '0 : acc[col];
  assign sum     = base + term;
  assign shifted = sum >> norm_r;
  assign sat     = (shifted > ACC_W'(255)) ? 8'hff
                                           : shifted[7:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start && !bad_cfg) state_d = RUN;
      end
      RUN: begin
        if (frame_start)
          state_d = bad_cfg ? IDLE : RUN;
        else if (accept && last_col && last_row)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) acc[col] <= sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_w_r   <= '0;
      lines_r    <= '0;
      dec_r      <= '0;
      norm_r     <= '0;
      for (int k = 0; k < MAX_Y_DEC; k++)
        coef_r[k] <= '0;
      col        <= '0;
      phase      <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_pix    <= '0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      out_valid  <= accept && last_phase;
      out_eol    <= accept && last_phase && last_col;
      frame_done <= accept && last_col && last_row;
      if (accept && last_phase) out_pix <= sat;
      if (frame_start) begin
        line_w_r <= line_w;
        lines_r  <= frame_lines;
        dec_r    <= dec_y;
        norm_r   <= normalize;
        for (int k = 0; k < MAX_Y_DEC; k++)
          coef_r[k] <= coef[k*COEF_W +: COEF_W];
        col     <= '0;
        phase   <= '0;
        row     <= '0;
        cfg_err <= bad_cfg;
      end else begin
        if (in_valid && state_q == IDLE) cfg_err <= 1'b1;
        if (accept) begin
          if (last_col) begin
            col   <= '0;
            phase <= last_phase ? 3'd0 : phase + 3'd1;
            row   <= last_row ? 11'd0 : row + 11'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_polyphase_fir_y.sv
// Bench for polyphase_fir_y: directed and random frames
// checked against a per-group weighted-sum reference.
module tb_polyphase_fir_y;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  line_w = '0;
  logic [10:0] frame_lines = '0;
  logic [2:0]  dec_y = '0;
  logic [27:0] coef = '0;
  logic [2:0]  normalize = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pix = '0;
  logic        out_valid;
  logic [7:0]  out_pix;
  logic        out_eol;
  logic        frame_done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int pix [16][16];
  int cf [7];

  polyphase_fir_y dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .line_w(line_w), .frame_lines(frame_lines),
    .dec_y(dec_y), .coef(coef), .normalize(normalize),
    .in_valid(in_valid), .in_pix(in_pix),
    .out_valid(out_valid), .out_pix(out_pix),
    .out_eol(out_eol), .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int model(int r, int c, int dec, int norm);
    int s = 0;
    int g0 = r - dec + 1;
    for (int k = 0; k < dec; k++)
      s += pix[g0+k][c] * cf[k];
    s = s >> norm;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("gap_valid", out_valid, 0);
    chk("gap_done", frame_done, 0);
  endtask

  // npix < w*lines aborts the frame early (no frame_done).
  task automatic run_frame(input int w, input int lines,
                           input int dec, input int norm,
                           input int npix, input bit gaps);
    bit bad;
    int r, c, total;
    bad = (dec < 1) || (dec > 7) || (w < 1) || (w > 640)
       || (lines < 1);
    total = w * lines;
    line_w      = 10'(w);
    frame_lines = 11'(lines);
    dec_y       = 3'(dec);
    normalize   = 3'(norm);
    for (int k = 0; k < 7; k++)
      coef[k*4 +: 4] = cf[k][3:0];
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_pix      = 8'haa;
    @(posedge clk); #1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    line_w      = 10'd3;
    dec_y       = 3'd5;
    coef        = '1;
    chk("start_valid", out_valid, 0);
    chk("start_cfg_err", cfg_err, 32'(bad));
    if (bad) return;
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      in_valid = 1'b1;
      in_pix   = 8'(pix[r][c]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if ((r + 1) % dec == 0) begin
        chk("out_valid", out_valid, 1);
        chk("out_pix", out_pix, model(r, c, dec, norm));
        chk("out_eol", out_eol, 32'(c == w - 1));
      end else begin
        chk("no_out_valid", out_valid, 0);
      end
      chk("frame_done", frame_done, 32'(i == total - 1));
      if (gaps && $urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pix[r][c] = int'($urandom_range(0, 255));
  endtask

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_pix", out_pix, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", cfg_err, 0);
    #10 rst_n = 1'b1;
    idle_cycle();

    // T1: unity pass-through
    for (int i = 0; i < 7; i++) cf[i] = 0;
    cf[0] = 1;
    for (int i = 0; i < 8; i++) pix[i/4][i%4] = 10 * (i + 1);
    run_frame(4, 2, 1, 0, 8, 0);

    // T2: 1-2-1 vertical kernel
    cf[0] = 1; cf[1] = 2; cf[2] = 1;
    for (int r = 0; r < 3; r++) begin
      pix[r][0] = 8; pix[r][1] = 4;
    end
    run_frame(2, 3, 3, 2, 6, 0);

    // T3: saturation
    cf[0] = 15; cf[1] = 15;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pix[r][c] = 255;
    run_frame(4, 4, 2, 0, 16, 1);

    // T4: trailing partial group discarded
    fill_random();
    cf[0] = 3; cf[1] = 5;
    run_frame(2, 3, 2, 1, 6, 0);

    // T5: restart mid-row, then reset mid-row
    fill_random();
    run_frame(5, 4, 2, 1, 7, 0);
    run_frame(5, 4, 2, 1, 20, 1);
    run_frame(6, 2, 2, 0, 3, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", frame_done, 0);
    #10 rst_n = 1'b1;
    fill_random();
    run_frame(3, 2, 2, 2, 6, 0);

    // In-range config but pixels in IDLE
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_pix_err", cfg_err, 1);
    chk("idle_pix_valid", out_valid, 0);

    // T6: bad configs, stray pixels, recovery
    run_frame(4, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pix   = 8'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bad_no_valid", out_valid, 0);
      chk("bad_err", cfg_err, 1);
    end
    run_frame(641, 2, 1, 0, 0, 0);
    run_frame(0, 2, 1, 0, 0, 0);
    run_frame(4, 0, 1, 0, 0, 0);
    fill_random();
    cf[0] = 7;
    run_frame(4, 2, 1, 3, 8, 0);

    // Random frames
    for (int t = 0; t < 25; t++) begin
      int w, l, d, n;
      w = int'($urandom_range(1, 12));
      d = int'($urandom_range(1, 7));
      l = int'($urandom_range(1, 16));
      n = int'($urandom_range(0, 7));
      for (int k = 0; k < 7; k++)
        cf[k] = int'($urandom_range(0, 15));
      fill_random();
      run_frame(w, l, d, n, w * l, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
